// File: rtl/terrain_arb_pkg.sv
// Shared types and default codes for the terrain-map access arbiter.
package terrain_arb_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_DIG   = 2'b10
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StWb,
    StDone
  } state_e;

  localparam int unsigned DefaultEmptyCode = 0;
  localparam int unsigned DefaultWallCode  = 15;

  // Encoding 2'b11 is reserved and behaves as a plain read.
  function automatic op_e decode_op(input logic [1:0] raw);
    case (raw)
      2'b01:   return OP_WRITE;
      2'b10:   return OP_DIG;
      default: return OP_READ;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IDX_W'((32'(ptr_i) + i) % N);
      if (!valid_o && req_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/terrain_access_arbiter.sv
// Round-robin arbiter sequencing READ/WRITE/DIG on the single terrain-map RAM port.
// Build option TERRAIN_ARB_FIXED_PRIO_EN gives requester 0 absolute priority.
module terrain_access_arbiter
  import terrain_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ROW_W  = 4,
  parameter int unsigned COL_W  = 4,
  parameter int unsigned ROWS   = 10,
  parameter int unsigned COLS   = 15,
  parameter int unsigned CODE_W = 4,
  parameter logic [CODE_W-1:0] EMPTY_CODE = CODE_W'(DefaultEmptyCode),
  parameter logic [CODE_W-1:0] WALL_CODE  = CODE_W'(DefaultWallCode)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    hold_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*2-1:0]      req_op_i,
  input  logic [N_REQ*ROW_W-1:0]  req_row_i,
  input  logic [N_REQ*COL_W-1:0]  req_col_i,
  input  logic [N_REQ*CODE_W-1:0] req_wdata_i,
  output logic [N_REQ-1:0]        ack_o,
  output logic [CODE_W-1:0]       rdata_o,
  output logic                    busy_o,
  output logic [ROW_W+COL_W-1:0]  mem_addr_o,
  output logic                    mem_we_o,
  output logic [CODE_W-1:0]       mem_wdata_o,
  input  logic [CODE_W-1:0]       mem_rdata_i
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  op_e                op_q, op_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [CODE_W-1:0]  wdata_q, wdata_d;
  logic [CODE_W-1:0]  rdata_q, rdata_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               rr_advance;
  logic               oor;

`ifdef TERRAIN_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] sub_ptr;
  logic [IDX_W-1:0] sub_idx;
  logic             sub_valid;

  // rr_ptr is kept in full requester numbering; shift it into the 1..N_REQ-1 sub-space.
  assign sub_ptr = (rr_ptr_q == '0) ? '0 : rr_ptr_q - 1'b1;

  rr_pick #(
    .N     (N_REQ - 1),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (req_i[N_REQ-1:1]),
    .ptr_i   (sub_ptr),
    .idx_o   (sub_idx),
    .valid_o (sub_valid)
  );

  always_comb begin
    pick_idx   = req_i[0] ? '0 : sub_idx + 1'b1;
    pick_valid = req_i[0] | sub_valid;
  end

  assign rr_advance = (win_q != '0);
`else
  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign rr_advance = 1'b1;
`endif

  assign oor        = (32'(row_q) >= ROWS) || (32'(col_q) >= COLS);
  assign mem_addr_o = {row_q, col_q};
  assign rdata_o    = rdata_q;
  assign busy_o     = (state_q != StIdle);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    op_d        = op_q;
    row_d       = row_q;
    col_d       = col_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    ack_o       = '0;

    case (state_q)
      StIdle: begin
        if (!hold_i && pick_valid) begin
          win_d   = pick_idx;
          state_d = StIssue;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
              op_d    = decode_op(req_op_i[i*2 +: 2]);
              row_d   = req_row_i[i*ROW_W +: ROW_W];
              col_d   = req_col_i[i*COL_W +: COL_W];
              wdata_d = req_wdata_i[i*CODE_W +: CODE_W];
            end
          end
        end
      end
      StIssue: begin
        if (oor) begin
          // Off-board cells read as wall and never touch the RAM.
          rdata_d = WALL_CODE;
          state_d = StDone;
        end else if (op_q == OP_WRITE) begin
          mem_we_o    = 1'b1;
          mem_wdata_o = wdata_q;
          rdata_d     = wdata_q;
          state_d     = StDone;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        rdata_d = mem_rdata_i;
        state_d = (op_q == OP_DIG) ? StWb : StDone;
      end
      StWb: begin
        mem_we_o    = 1'b1;
        mem_wdata_o = EMPTY_CODE;
        state_d     = StDone;
      end
      StDone: begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
          ack_o[i] = (win_q == IDX_W'(i));
        end
        if (rr_advance) begin
          rr_ptr_d = (32'(win_q) == N_REQ - 1) ? '0 : win_q + 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      win_q    <= '0;
      op_q     <= OP_READ;
      row_q    <= '0;
      col_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      op_q     <= op_d;
      row_q    <= row_d;
      col_q    <= col_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_terrain_access_arbiter.sv
// Directed self-checking bench for terrain_access_arbiter with a 1-cycle-latency RAM model.
module tb_terrain_access_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic [3:0]  req;
  logic [7:0]  req_op;
  logic [15:0] req_row;
  logic [15:0] req_col;
  logic [15:0] req_wdata;
  logic [3:0]  ack;
  logic [3:0]  rdata;
  logic        busy;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wdata;
  logic [3:0]  mem_rdata;

  logic [3:0]  ram [256];
  int          we_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  terrain_access_arbiter u_dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .hold_i      (hold),
    .req_i       (req),
    .req_op_i    (req_op),
    .req_row_i   (req_row),
    .req_col_i   (req_col),
    .req_wdata_i (req_wdata),
    .ack_o       (ack),
    .rdata_o     (rdata),
    .busy_o      (busy),
    .mem_addr_o  (mem_addr),
    .mem_we_o    (mem_we),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      we_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [3:0] mask, input logic [1:0] op, input logic [3:0] row,
                           input logic [3:0] col, input logic [3:0] wd);
    for (int i = 0; i < 4; i++) begin
      req_op[i*2 +: 2]    = op;
      req_row[i*4 +: 4]   = row;
      req_col[i*4 +: 4]   = col;
      req_wdata[i*4 +: 4] = wd;
    end
    req = mask;
  endtask

  // One transaction from IDLE; lat counts cycles from the sampling edge to the ack cycle.
  task automatic go(input logic [3:0] mask, input logic [1:0] op, input logic [3:0] row,
                    input logic [3:0] col, input logic [3:0] wd,
                    output int lat, output logic [3:0] ack_v, output logic [3:0] rd_v,
                    output int we_n, output int we_at, output logic [3:0] we_d,
                    output logic [7:0] addr1);
    set_lanes(mask, op, row, col, wd);
    lat = 99; ack_v = '0; rd_v = '0; we_n = 0; we_at = 0; we_d = '0; addr1 = '0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) addr1 = mem_addr;
      if (mem_we) begin
        we_n++;
        we_at = k;
        we_d  = mem_wdata;
      end
      if (ack !== 4'b0000) begin
        lat   = k;
        ack_v = ack;
        rd_v  = rdata;
        break;
      end
    end
    req = '0;
    tick();
  endtask

  int         lat, we_n, we_at, bad, w0, k;
  logic [3:0] ack_v, rd_v, we_d;
  logic [7:0] addr1;
  logic [3:0] rr_exp [5];

  initial begin
`ifdef TERRAIN_ARB_FIXED_PRIO_EN
    rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    for (int i = 0; i < 256; i++) ram[i] = 4'h0;
    ram[8'h35] = 4'd7;
    ram[8'h11] = 4'd9;
    ram[8'h44] = 4'd5;
    reset = 1'b1; hold = 1'b0;
    set_lanes(4'b0000, 2'b00, 4'd0, 4'd0, 4'd0);
    tick(); tick();

    check_eq("rst_ack", ack, 4'b0000);
    check_eq("rst_rdata", rdata, 4'h0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_we", mem_we, 1'b0);
    check_eq("rst_addr", mem_addr, 8'h00);
    check_eq("rst_wdata", mem_wdata, 4'h0);
    reset = 1'b0;
    tick();

    go(4'b0100, 2'b00, 4'd3, 4'd5, 4'd0, lat, ack_v, rd_v, we_n, we_at, we_d, addr1);
    check_eq("rd_addr_t1", addr1, 8'h35);
    check_eq("rd_lat", lat, 3);
    check_eq("rd_ack", ack_v, 4'b0100);
    check_eq("rd_data", rd_v, 4'd7);
    check_eq("rd_no_we", we_n, 0);

    go(4'b0001, 2'b10, 4'd1, 4'd1, 4'd0, lat, ack_v, rd_v, we_n, we_at, we_d, addr1);
    check_eq("dig_lat", lat, 4);
    check_eq("dig_ack", ack_v, 4'b0001);
    check_eq("dig_old", rd_v, 4'd9);
    check_eq("dig_we_n", we_n, 1);
    check_eq("dig_we_at", we_at, 3);
    check_eq("dig_we_data", we_d, 4'h0);

    go(4'b0001, 2'b00, 4'd1, 4'd1, 4'd0, lat, ack_v, rd_v, we_n, we_at, we_d, addr1);
    check_eq("dig_readback", rd_v, 4'h0);
    check_eq("dig_rb_lat", lat, 3);

    go(4'b1000, 2'b11, 4'd3, 4'd5, 4'd0, lat, ack_v, rd_v, we_n, we_at, we_d, addr1);
    check_eq("op11_lat", lat, 3);
    check_eq("op11_data", rd_v, 4'd7);
    check_eq("op11_no_we", we_n, 0);

    go(4'b0010, 2'b01, 4'd12, 4'd3, 4'd5, lat, ack_v, rd_v, we_n, we_at, we_d, addr1);
    check_eq("oor_row_lat", lat, 2);
    check_eq("oor_row_no_we", we_n, 0);
    check_eq("oor_row_wall", rd_v, 4'd15);

    go(4'b0010, 2'b10, 4'd2, 4'd15, 4'd0, lat, ack_v, rd_v, we_n, we_at, we_d, addr1);
    check_eq("oor_col_lat", lat, 2);
    check_eq("oor_col_no_we", we_n, 0);
    check_eq("oor_col_wall", rd_v, 4'd15);

    go(4'b1000, 2'b01, 4'd2, 4'd2, 4'd6, lat, ack_v, rd_v, we_n, we_at, we_d, addr1);
    check_eq("wr_lat", lat, 2);
    check_eq("wr_we_at", we_at, 1);
    check_eq("wr_we_data", we_d, 4'd6);
    check_eq("wr_rdata", rd_v, 4'd6);
    go(4'b0001, 2'b00, 4'd2, 4'd2, 4'd0, lat, ack_v, rd_v, we_n, we_at, we_d, addr1);
    check_eq("wr_readback", rd_v, 4'd6);

    hold = 1'b1;
    set_lanes(4'b0010, 2'b00, 4'd3, 4'd5, 4'd0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack !== 4'b0000 || busy !== 1'b0) bad++;
    end
    check_eq("hold_idle", bad, 0);
    hold = 1'b0;
    go(4'b0010, 2'b00, 4'd3, 4'd5, 4'd0, lat, ack_v, rd_v, we_n, we_at, we_d, addr1);
    check_eq("hold_rel_lat", lat, 3);
    check_eq("hold_rel_ack", ack_v, 4'b0010);

    // Requester 1 was last granted, so rr_ptr sits at 2 before the aborting reset.
    set_lanes(4'b0100, 2'b10, 4'd4, 4'd4, 4'd0);
    tick(); tick();
    check_eq("abort_busy_pre", busy, 1'b1);
    w0 = we_cnt;
    reset = 1'b1;
    #1;
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_ack", ack, 4'b0000);
    check_eq("abort_rdata", rdata, 4'h0);
    check_eq("abort_addr", mem_addr, 8'h00);
    req = '0;
    tick();
    reset = 1'b0;
    tick(); tick();
    check_eq("abort_no_wb", we_cnt - w0, 0);
    check_eq("abort_cell", ram[8'h44], 4'd5);
    go(4'b1010, 2'b00, 4'd3, 4'd5, 4'd0, lat, ack_v, rd_v, we_n, we_at, we_d, addr1);
    check_eq("abort_next_ack", ack_v, 4'b0010);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    set_lanes(4'b1111, 2'b00, 4'd3, 4'd5, 4'd0);
    for (int n = 0; n < 5; n++) begin
      k = 0;
      do begin
        tick();
        k++;
      end while (ack === 4'b0000 && k < 10);
      check_eq("rr_ack", ack, rr_exp[n]);
      check_eq("rr_gap", k, (n == 0) ? 3 : 4);
    end
    req = '0;
    tick(); tick();
    check_eq("end_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/terrain_access_arbiter.md
Name: terrain_access_arbiter

Overview:
Shares the single terrain-map RAM port between the objects that query or modify the board: player, alien pair, gold pair and game controller. Round-robin arbitration with req/ack handshakes. Sequences READ, WRITE and DIG (read-modify-write that clears a cell and returns its old code). Sits between the moving-object blocks and the terrain map storage, all on clk_25.

Parameters:
N_REQ, 4, number of requesters (2..8)
ROW_W, 4, row index width
COL_W, 4, column index width; RAM address = {row,col}
ROWS, 10, valid rows (0..ROWS-1)
COLS, 15, valid columns (0..COLS-1)
CODE_W, 4, terrain cell code width
EMPTY_CODE, 0, code written by DIG
WALL_CODE, 15, code returned for out-of-range cells

Ports:
clk  in  1  system clock (clk_25)
reset  in  1  asynchronous, active-high reset
hold  in  1  1 = no new grants (transaction in flight completes)
req  in  N_REQ  per-requester request, held until ack
req_op  in  N_REQ*2  per-requester op: 00 READ, 01 WRITE, 10 DIG, 11 treated as READ
req_row  in  N_REQ*ROW_W  per-requester row
req_col  in  N_REQ*COL_W  per-requester column
req_wdata  in  N_REQ*CODE_W  per-requester write code
ack  out  N_REQ  one-cycle completion pulse to the winner
rdata  out  CODE_W  read/old code, valid while ack is high
busy  out  1  high in every state except IDLE
mem_addr  out  ROW_W+COL_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  CODE_W  RAM write data
mem_rdata  in  CODE_W  RAM read data, 1-cycle latency after mem_addr

Behaviour:
- Reset: state=IDLE, rr_ptr=0, ack=0, rdata=0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0.
- States: IDLE, ISSUE, WAIT, WB, DONE.
- IDLE: if hold=0 and any req, pick the first set req at or after rr_ptr (wrapping). Latch winner index, op, row, col, wdata. Go to ISSUE.
- ISSUE: drive mem_addr={row,col}. WRITE: mem_we=1, mem_wdata=wdata, next DONE. READ/DIG: mem_we=0, next WAIT.
- WAIT: capture mem_rdata into rdata. Next WB if DIG, else DONE.
- WB: mem_we=1, mem_wdata=EMPTY_CODE, same address, next DONE.
- DONE: ack[winner]=1 for exactly one cycle. rdata is held. For WRITE, rdata=wdata. Set rr_ptr=(winner+1) mod N_REQ. Next IDLE.
- Latency (req sampled in IDLE at cycle t): ack at WRITE t+2, READ t+3, DIG t+4.
- mem_we is high only in ISSUE (WRITE) or WB.
- Out-of-range cell (row>=ROWS or col>=COLS): no mem access at all (mem_we stays 0). ISSUE goes straight to DONE with rdata=WALL_CODE. Ack comes at t+2 for every op.
- A requester dropping req mid-transaction does not abort it; ack still pulses.
- A requester whose req is still high after its ack is eligible again in the next IDLE; round robin keeps it from starving others.
- hold rising mid-transaction has no effect until return to IDLE.
- Reset asserted mid-transaction aborts immediately to the reset values; no ack is issued.
- Back-to-back: one IDLE cycle separates consecutive transactions.

Optional Feature:
TERRAIN_ARB_FIXED_PRIO_EN
- Defined: requester 0 (player) always wins if its req is set. Remaining requesters arbitrate round-robin among themselves; rr_ptr is not advanced by requester-0 grants.
- Undefined: pure round-robin over all N_REQ, as above.

Decomposition:
- Package terrain_arb_pkg: op enum (OP_READ, OP_WRITE, OP_DIG), state enum, EMPTY_CODE/WALL_CODE defaults.
- Sub-module rr_pick: combinational round-robin priority picker (req vector, rr_ptr) -> winner index plus valid. Reused by the fixed-priority variant over requesters 1..N_REQ-1.

Test Plan:
- Single READ by requester 2 at (3,5), RAM holds 7 -> mem_addr=0x35 at t+1, ack[2] at t+3, rdata=7, mem_we never high.
- DIG by requester 0 at (1,1), cell=9 -> ack[0] at t+4, rdata=9, mem_we=1 with mem_wdata=0 at t+3; a follow-up READ returns 0.
- req=4'b1111 held continuously -> ack order 0,1,2,3,0, each one cycle; with TERRAIN_ARB_FIXED_PRIO_EN the order is 0,0,0 (requester 0 starves the others while held).
- WRITE to (12,3) (row >= ROWS) -> no mem_we, ack at t+2, rdata=15.
- hold=1 while req[1]=1 for 10 cycles -> no ack, busy=0; hold drops -> ack[1] 3 cycles later for READ.
- reset pulsed during WAIT of a DIG -> no ack, no WB write, rr_ptr=0, outputs at reset values; the next grant goes to the lowest set req.
